multiport_regfile: RTL and testbench
====================================

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter WIDTH, default 64: bit width of every register and data port.
REQ-002 Parameter ADDR_BITS, default 5: address width; register count N = 2**ADDR_BITS.
REQ-003 Parameter ZERO_REG, default 1: when 1, register N-1 is hardwired to zero; when 0, all N registers are writable.
REQ-004 clk  input  1  single clock; all register updates occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 we0  input  1  write enable, write port 0.
REQ-007 waddr0  input  ADDR_BITS  destination register, write port 0.
REQ-008 wdata0  input  WIDTH  write data, write port 0.
REQ-009 we1  input  1  write enable, write port 1.
REQ-010 waddr1  input  ADDR_BITS  destination register, write port 1.
REQ-011 wdata1  input  WIDTH  write data, write port 1.
REQ-012 raddr0, raddr1  input  ADDR_BITS each  read addresses, read ports 0 and 1.
REQ-013 rdata0, rdata1  output  WIDTH each  read data, read ports 0 and 1.

Function
REQ-014 Each write port SHALL decode its address into an N-bit one-hot enable gated by its we; with we low, the enable vector SHALL be all zeros.
REQ-015 At a rising clk edge with weX high, the register at waddrX SHALL be loaded with wdataX; all other registers SHALL hold their values.
REQ-016 When we0 and we1 are both high with waddr0 == waddr1, port 1 SHALL win: the register takes wdata1.
REQ-017 When both ports write different addresses in the same cycle, both writes SHALL complete in that cycle.
REQ-018 Reads SHALL be combinational: rdataX SHALL equal the current content of register raddrX with no clock latency.
REQ-019 With ZERO_REG=1, writes to address N-1 SHALL be discarded, and reads of N-1 SHALL return 0 on both read ports.
REQ-020 Both read ports SHALL be independent; identical raddr0 and raddr1 SHALL return identical data.
REQ-021 Addresses SHALL be treated as unsigned; every address in 0..N-1 is valid, so no out-of-range case exists.

Reset
REQ-022 When reset goes low, all registers SHALL clear to 0 immediately, independent of clk.
REQ-023 While reset is low, writes SHALL be ignored and rdata0/rdata1 SHALL read 0.
REQ-024 Reset asserted in the same cycle as a write SHALL win; the write is lost.
REQ-025 After reset deasserts, the first rising clk edge SHALL accept writes normally.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN, when defined, SHALL enable write-to-read forwarding: if weX is high and waddrX == raddrY, then rdataY SHALL equal wdataX in that same cycle. Forwarding from port 1 takes priority over port 0, and no forwarding occurs to the zero register when ZERO_REG=1.
REQ-027 Without REGFILE_BYPASS_EN, rdataY SHALL show the old register value until after the write edge; no forwarding logic SHALL be present.

Verification
REQ-028 Reset low, then high; read all 32 addresses on both ports -> every read returns 0.
REQ-029 Write 0xDEADBEEF_00000001 to X5 via port 0; read X5 on port 1 on the next cycle -> 0xDEADBEEF_00000001; X4 and X6 remain 0.
REQ-030 Same cycle: port 0 writes 0x11 to X7 and port 1 writes 0x22 to X7; next cycle read X7 -> 0x22. Same cycle: port 0 writes 0x33 to X8 and port 1 writes 0x44 to X9 -> X8=0x33, X9=0x44.
REQ-031 With ZERO_REG=1, write 0xFFFF to X31 -> reads of X31 return 0 on both ports; with ZERO_REG=0, the same write reads back 0xFFFF.
REQ-032 Write 0xABCD to X3 with raddr0=3 in the same cycle -> with REGFILE_BYPASS_EN, rdata0=0xABCD before the edge; without it, rdata0 holds the prior value (0) until after the edge.
REQ-033 After loading X1..X30 with nonzero values, pulse reset low mid-cycle -> all reads are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/multiport_regfile.sv
// Two-write / two-read register file with optional hardwired zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_regfile #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we0,
    input  logic [ADDR_BITS-1:0] waddr0,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic                 we1,
    input  logic [ADDR_BITS-1:0] waddr1,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic [ADDR_BITS-1:0] raddr0,
    input  logic [ADDR_BITS-1:0] raddr1,
    output logic [WIDTH-1:0]     rdata0,
    output logic [WIDTH-1:0]     rdata1
);

    localparam int unsigned NumRegs = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(NumRegs - 1);

    logic [WIDTH-1:0]   regFile [NumRegs];
    logic [NumRegs-1:0] wrEn0;
    logic [NumRegs-1:0] wrEn1;

    // One-hot write enables; the zero register never gets an enable
    always_comb begin
        wrEn0 = '0;
        wrEn1 = '0;
        if (we0) wrEn0[waddr0] = 1'b1;
        if (we1) wrEn1[waddr1] = 1'b1;
        if (ZERO_REG != 0) begin
            wrEn0[LastAddr] = 1'b0;
            wrEn1[LastAddr] = 1'b0;
        end
    end

    // Port 1 wins a same-address collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) regFile[i] <= '0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                if (wrEn1[i])      regFile[i] <= wdata1;
                else if (wrEn0[i]) regFile[i] <= wdata0;
            end
        end
    end

    always_comb begin
        rdata0 = regFile[raddr0];
`ifdef REGFILE_BYPASS_EN
        if (wrEn1[raddr0])      rdata0 = wdata1;
        else if (wrEn0[raddr0]) rdata0 = wdata0;
`endif
        if ((ZERO_REG != 0 && raddr0 == LastAddr) || !reset) rdata0 = '0;
    end

    always_comb begin
        rdata1 = regFile[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (wrEn1[raddr1])      rdata1 = wdata1;
        else if (wrEn0[raddr1]) rdata1 = wdata0;
`endif
        if ((ZERO_REG != 0 && raddr1 == LastAddr) || !reset) rdata1 = '0;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus.
module tb_multiport_regfile;

    localparam int unsigned W = 64;
    localparam int unsigned A = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        string        nm;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] n0;
        logic [W-1:0] n1;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         we0 = 1'b0, we1 = 1'b0;
    logic [A-1:0] waddr0 = '0, waddr1 = '0, raddr0 = '0, raddr1 = '0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic [W-1:0] rdata0, rdata1, nzData0, nzData1;
    logic         reqValid = 1'b0;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    multiport_regfile #(.WIDTH(W), .ADDR_BITS(A), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1)
    );

    multiport_regfile #(.WIDTH(W), .ADDR_BITS(A), .ZERO_REG(0)) dutNz (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(nzData0), .rdata1(nzData1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every presented read against the oldest expectation
    always @(negedge clk) begin
        if (reqValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk({e.nm, "/rd0"},   rdata0,  e.e0);
                chk({e.nm, "/rd1"},   rdata1,  e.e1);
                chk({e.nm, "/nzrd0"}, nzData0, e.n0);
                chk({e.nm, "/nzrd1"}, nzData1, e.n1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        we0 = 1'b0;
        we1 = 1'b0;
        reqValid = 1'b0;
    endtask

    task automatic wr(input logic w0, input int a0, input logic [W-1:0] d0,
                      input logic w1, input int a1, input logic [W-1:0] d1);
        we0 = w0; waddr0 = A'(a0); wdata0 = d0;
        we1 = w1; waddr1 = A'(a1); wdata1 = d1;
        cyc();
    endtask

    task automatic post(input string nm, input int a0, input int a1,
                        input logic [W-1:0] e0, input logic [W-1:0] e1,
                        input logic [W-1:0] n0, input logic [W-1:0] n1);
        exp_t e;
        raddr0 = A'(a0);
        raddr1 = A'(a1);
        e.nm = nm; e.e0 = e0; e.e1 = e1; e.n0 = n0; e.n1 = n1;
        expQ.push_back(e);
        reqValid = 1'b1;
    endtask

    task automatic rd(input string nm, input int a0, input int a1,
                      input logic [W-1:0] e0, input logic [W-1:0] e1,
                      input logic [W-1:0] n0, input logic [W-1:0] n1);
        post(nm, a0, a1, e0, e1, n0, n1);
        cyc();
    endtask

    initial begin
        #12 reset = 1'b1;
        @(posedge clk);
        #1;

        // Everything reads zero out of reset
        for (int i = 0; i < 32; i++) rd("reset_clear", i, 31 - i, '0, '0, '0, '0);

        // Single write on port 0
        wr(1'b1, 5, 64'hDEADBEEF_00000001, 1'b0, 0, '0);
        rd("x5_write", 4, 5, '0, 64'hDEADBEEF_00000001, '0, 64'hDEADBEEF_00000001);
        rd("x5_neighbors", 6, 5, '0, 64'hDEADBEEF_00000001, '0, 64'hDEADBEEF_00000001);

        // Same-address collision and dual distinct writes
        wr(1'b1, 7, 64'h11, 1'b1, 7, 64'h22);
        rd("collide_x7", 7, 7, 64'h22, 64'h22, 64'h22, 64'h22);
        wr(1'b1, 8, 64'h33, 1'b1, 9, 64'h44);
        rd("dual_x8_x9", 8, 9, 64'h33, 64'h44, 64'h33, 64'h44);

        // Zero register behaviour
        wr(1'b1, 31, 64'hFFFF, 1'b0, 0, '0);
        rd("x31_port0", 31, 31, '0, '0, 64'hFFFF, 64'hFFFF);
        wr(1'b0, 0, '0, 1'b1, 31, 64'h1234);
        rd("x31_port1", 31, 30, '0, '0, 64'h1234, '0);

        // Same-cycle write/read: forwarded or old value depending on build
        we0 = 1'b1; waddr0 = A'(3); wdata0 = 64'hABCD;
        rd("x3_same_cycle", 3, 3, Bypass ? 64'hABCD : '0, Bypass ? 64'hABCD : '0,
           Bypass ? 64'hABCD : '0, Bypass ? 64'hABCD : '0);
        rd("x3_after_edge", 3, 2, 64'hABCD, '0, 64'hABCD, '0);

        we0 = 1'b1; waddr0 = A'(10); wdata0 = 64'hAA;
        we1 = 1'b1; waddr1 = A'(10); wdata1 = 64'hBB;
        rd("x10_fwd_prio", 10, 9, Bypass ? 64'hBB : '0, 64'h44, Bypass ? 64'hBB : '0, 64'h44);
        rd("x10_after_edge", 10, 10, 64'hBB, 64'hBB, 64'hBB, 64'hBB);

        we0 = 1'b1; waddr0 = A'(31); wdata0 = 64'h5555;
        rd("x31_no_fwd", 31, 31, '0, '0, Bypass ? 64'h5555 : 64'h1234, Bypass ? 64'h5555 : 64'h1234);

        // Fill X1..X30 using both ports
        for (int i = 1; i <= 29; i += 2)
            wr(1'b1, i, 64'h1000 + 64'(i), 1'b1, i + 1, 64'h1000 + 64'(i + 1));
        rd("fill_x1_x30", 1, 30, 64'h1001, 64'h101E, 64'h1001, 64'h101E);
        rd("fill_x15_x16", 15, 16, 64'h100F, 64'h1010, 64'h100F, 64'h1010);

        // Mid-cycle reset clears before any clock edge
        post("midcycle_reset", 1, 30, '0, '0, '0, '0);
        #2 reset = 1'b0;
        cyc();

        // Write during reset is lost; reads stay zero
        we0 = 1'b1; waddr0 = A'(2); wdata0 = 64'h99;
        rd("write_in_reset", 2, 2, '0, '0, '0, '0);
        reset = 1'b1;
        rd("post_reset_x2", 2, 31, '0, '0, '0, '0);
        wr(1'b1, 2, 64'h77, 1'b0, 0, '0);
        rd("first_write_after_reset", 2, 5, 64'h77, '0, 64'h77, '0);

        for (int t = 0; t < 100 && expQ.size() != 0; t++) cyc();
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
